// File: rtl/keypad_pkg.sv
// Shared keypad types and the multi-tap key table: key code layout, key roles,
// letter group base characters and group sizes.
package keypad_pkg;

  // One scan result: valid flag plus the {row, col} position of the single active key.
  typedef struct packed {
    logic       valid;
    logic [1:0] row;
    logic [1:0] col;
  } key_code_t;

  typedef enum logic [2:0] {
    RoleLetter,
    RoleCommit,
    RoleClear,
    RoleSubmit,
    RoleNone
  } key_role_e;

  localparam logic [7:0] AsciiSpace = 8'h20;

  // Phone layout on a 4x4 pad: 2..9 carry the letter groups, '*' commits,
  // '#' clears and 'D' submits the word.
  function automatic key_role_e key_role(input key_code_t k);
    if (!k.valid) return RoleNone;
    case ({k.row, k.col})
      4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: return RoleLetter;
      4'hC:    return RoleCommit;
      4'hE:    return RoleClear;
      4'hF:    return RoleSubmit;
      default: return RoleNone;
    endcase
  endfunction

  // Letter group index: 0=ABC 1=DEF 2=GHI 3=JKL 4=MNO 5=PQRS 6=TUV 7=WXYZ.
  function automatic logic [2:0] key_group(input key_code_t k);
    case ({k.row, k.col})
      4'h1:    return 3'd0;
      4'h2:    return 3'd1;
      4'h4:    return 3'd2;
      4'h5:    return 3'd3;
      4'h6:    return 3'd4;
      4'h8:    return 3'd5;
      4'h9:    return 3'd6;
      4'hA:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // ASCII of the first letter in each group.
  function automatic logic [7:0] group_base(input logic [2:0] g);
    case (g)
      3'd0:    return 8'h41;
      3'd1:    return 8'h44;
      3'd2:    return 8'h47;
      3'd3:    return 8'h4A;
      3'd4:    return 8'h4D;
      3'd5:    return 8'h50;
      3'd6:    return 8'h54;
      default: return 8'h57;
    endcase
  endfunction

  function automatic logic [2:0] group_size(input logic [2:0] g);
    return ((g == 3'd5) || (g == 3'd7)) ? 3'd4 : 3'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner and per-key debouncer. Produces one key_event per complete
// press/release cycle, carrying the debounced key_code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DWELL     = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic      clk,
  input  logic      nRst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic      key_event,
  output key_code_t key_code,
  output logic      key_error
);

  localparam int unsigned DwellW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int unsigned DbW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} db_state_e;

  logic [DwellW-1:0] dwell_q;
  logic [1:0]        col_idx_q;
  logic              acc_valid_q, acc_multi_q, key_error_q;
  logic [3:0]        acc_code_q;

  db_state_e         state_q;
  key_code_t         cand_q;
  logic [DbW-1:0]    db_cnt_q, db_next;
  logic              key_event_q;

  logic              sample, scan_done, m_valid, m_multi;
  logic [2:0]        n_hits;
  logic [1:0]        hit_row;
  logic [3:0]        m_code;
  key_code_t         scan_code;

  assign col       = 4'b0001 << col_idx_q;
  assign key_event = key_event_q;
  assign key_code  = cand_q;
  assign key_error = key_error_q;

  // Merge this column's row sample into the running scan result.
  always_comb begin
    sample  = (dwell_q == DwellW'(SCAN_DWELL - 1));
    n_hits  = 3'd0;
    hit_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row[i]) begin
        n_hits  = n_hits + 3'd1;
        hit_row = 2'(i);
      end
    end
    m_multi   = acc_multi_q || (n_hits > 3'd1) || ((n_hits == 3'd1) && acc_valid_q);
    m_valid   = acc_valid_q || (n_hits != 3'd0);
    m_code    = acc_valid_q ? acc_code_q : {hit_row, col_idx_q};
    scan_done = sample && (col_idx_q == 2'd3);
    db_next   = db_cnt_q + DbW'(1);
    // A multi-key scan is reported as no key at all.
    scan_code.valid = m_valid && !m_multi;
    scan_code.row   = m_code[3:2];
    scan_code.col   = m_code[1:0];
  end

  // Column rotation, dwell timing and per-scan accumulation.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      acc_valid_q <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_code_q  <= 4'd0;
      key_error_q <= 1'b0;
    end else begin
      key_error_q <= scan_done && m_multi;
      if (sample) begin
        dwell_q   <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        if (col_idx_q == 2'd3) begin
          acc_valid_q <= 1'b0;
          acc_multi_q <= 1'b0;
          acc_code_q  <= 4'd0;
        end else begin
          acc_valid_q <= m_valid;
          acc_multi_q <= m_multi;
          acc_code_q  <= m_code;
        end
      end else begin
        dwell_q <= dwell_q + DwellW'(1);
      end
    end
  end

  // Debounce FSM, stepped once per scan; the event fires on the release exit.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= StIdle;
      cand_q      <= '0;
      db_cnt_q    <= '0;
      key_event_q <= 1'b0;
    end else begin
      key_event_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          StIdle: begin
            if (scan_code.valid) begin
              cand_q   <= scan_code;
              db_cnt_q <= DbW'(1);
              state_q  <= (DEBOUNCE_SCANS <= 1) ? StHeld : StPressDb;
            end
          end
          StPressDb: begin
            if (scan_code == cand_q) begin
              db_cnt_q <= db_next;
              if (db_next >= DbMax) state_q <= StHeld;
            end else begin
              state_q <= StIdle;
            end
          end
          StHeld: begin
            if (scan_code != cand_q) begin
              db_cnt_q <= DbW'(1);
              if (DEBOUNCE_SCANS <= 1) begin
                state_q     <= StIdle;
                key_event_q <= 1'b1;
              end else begin
                state_q <= StReleaseDb;
              end
            end
          end
          StReleaseDb: begin
            if (scan_code == cand_q) begin
              state_q <= StHeld;
            end else begin
              db_cnt_q <= db_next;
              if (db_next >= DbMax) begin
                state_q     <= StIdle;
                key_event_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_multitap_decoder.sv
// Multi-tap keypad text entry: repeated taps on a letter key cycle through its
// group, '*' commits the pending letter, '#' clears it, 'D' submits the word.
// Optional macro KEYPAD_AUTOCOMMIT_EN adds an idle timer that commits a pending
// letter after TAP_TIMEOUT cycles without a key event.
module keypad_multitap_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DWELL     = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned TAP_TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] preview,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       word_submit,
  output logic       clear,
  output logic       key_error
);

  logic       key_event;
  key_code_t  key_code;
  key_role_e  role;
  logic [2:0] grp, tap_inc;
  logic [7:0] cur_letter;
  logic       tap_wrap, tmo_fire;

  logic       pending_q, char_valid_q, word_submit_q, clear_q;
  logic [2:0] group_q;
  logic [1:0] tap_q;
  logic [7:0] char_out_q;

  keypad_scanner #(
    .SCAN_DWELL    (SCAN_DWELL),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scanner (
    .clk      (clk),
    .nRst     (nRst),
    .row      (row),
    .col      (col),
    .key_event(key_event),
    .key_code (key_code),
    .key_error(key_error)
  );

  assign role        = key_role(key_code);
  assign grp         = key_group(key_code);
  assign cur_letter  = group_base(group_q) + {6'd0, tap_q};
  assign tap_inc     = {1'b0, tap_q} + 3'd1;
  assign tap_wrap    = (tap_inc == group_size(group_q));
  assign preview     = pending_q ? cur_letter : AsciiSpace;
  assign char_out    = char_out_q;
  assign char_valid  = char_valid_q;
  assign word_submit = word_submit_q;
  assign clear       = clear_q;

`ifdef KEYPAD_AUTOCOMMIT_EN
  localparam int unsigned TmoW = (TAP_TIMEOUT > 1) ? $clog2(TAP_TIMEOUT) : 1;
  logic [TmoW-1:0] tmo_q;

  assign tmo_fire = pending_q && !key_event && (tmo_q == TmoW'(TAP_TIMEOUT - 1));

  // Idle timer: restarts on every key event and only runs while a letter is pending.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tmo_q <= '0;
    end else if (key_event || !pending_q || tmo_fire) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end
`else
  // No timer in this build; the parameter stays on the interface unused.
  assign tmo_fire = 1'b0 && (TAP_TIMEOUT != 0);
`endif

  // Pending-letter state and registered one-cycle output pulses.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pending_q     <= 1'b0;
      group_q       <= 3'd0;
      tap_q         <= 2'd0;
      char_out_q    <= 8'h00;
      char_valid_q  <= 1'b0;
      word_submit_q <= 1'b0;
      clear_q       <= 1'b0;
    end else begin
      char_valid_q  <= 1'b0;
      word_submit_q <= 1'b0;
      clear_q       <= 1'b0;
      if (key_event) begin
        case (role)
          RoleLetter: begin
            if (pending_q && (group_q == grp)) begin
              tap_q <= tap_wrap ? 2'd0 : tap_inc[1:0];
            end else begin
              // A different group silently replaces the pending letter.
              pending_q <= 1'b1;
              group_q   <= grp;
              tap_q     <= 2'd0;
            end
          end
          RoleCommit: begin
            if (pending_q) begin
              char_out_q   <= cur_letter;
              char_valid_q <= 1'b1;
              pending_q    <= 1'b0;
            end
          end
          RoleClear: begin
            pending_q <= 1'b0;
            tap_q     <= 2'd0;
            clear_q   <= 1'b1;
          end
          RoleSubmit: word_submit_q <= 1'b1;
          default: ;
        endcase
      end else if (tmo_fire) begin
        char_out_q   <= cur_letter;
        char_valid_q <= 1'b1;
        pending_q    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/keypad_multitap_decoder.md
KEYPAD_MULTITAP_DECODER -- requirements
Module: keypad_multitap_decoder

Interface
REQ-001 SHALL have parameter SCAN_DWELL, default 16, meaning clock cycles each column is driven before advancing.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive full scans a key code must be stable to count as pressed or released.
REQ-003 SHALL have parameter TAP_TIMEOUT, default 50000, meaning idle cycles after release before a pending letter auto-commits; used only with KEYPAD_AUTOCOMMIT_EN.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock; nRst input 1 asynchronous active-low reset.
REQ-005 SHALL have port row, input, 4 bits: keypad rows, active-high, one per row R0..R3.
REQ-006 SHALL have port col, output, 4 bits: one-hot column drive, C0..C3.
REQ-007 SHALL have port preview, output, 8 bits: ASCII of the pending letter; 8'h20 when none is pending.
REQ-008 SHALL have port char_out, output, 8 bits: ASCII of the committed letter, valid while char_valid is high.
REQ-009 SHALL have ports char_valid, word_submit, clear and key_error, outputs, 1 bit each, all one-cycle pulses.

Function
REQ-010 SHALL rotate col C0->C1->C2->C3->C0, holding each column for SCAN_DWELL cycles, and SHALL sample row on the last dwell cycle of each column.
REQ-011 SHALL form a 5-bit key code per scan: valid flag plus {row,col} index. More than one active row/column in a scan SHALL produce key_error for 1 cycle, and that scan SHALL count as no key.
REQ-012 SHALL run the debounce FSM states IDLE, PRESS_DB, HELD and RELEASE_DB; a key event fires once on the HELD->RELEASE_DB->IDLE exit, so a held key produces exactly one event.
REQ-013 SHALL map keys through the package table: 8 letter keys (ABC, DEF, GHI, JKL, MNO, PQRS, TUV, WXYZ), R3C0 = commit letter, R3C2 = clear, R3C3 = submit word, and ignore the remaining keys.
REQ-014 SHALL handle a repeated letter key by advancing the tap index modulo group size, so PQRS wraps S->P.
REQ-015 SHALL handle a different letter key while a letter is pending by discarding the pending letter and loading the first letter of the new group; no char_valid SHALL be issued.
REQ-016 SHALL handle commit with a letter pending by driving char_out with that letter and pulsing char_valid the cycle after the release event, then setting preview to 8'h20. Commit with nothing pending SHALL do nothing.
REQ-017 SHALL handle clear by dropping the pending letter and pulsing clear for 1 cycle; submit word SHALL pulse word_submit without affecting any pending letter.
REQ-018 SHALL drive preview combinationally from the registered group and tap index.

Reset
REQ-019 SHALL, with nRst low, immediately set col=4'b0001, preview=8'h20, char_out=8'h00, all pulse outputs 0, FSM=IDLE, and clear the scan counters and pending state.
REQ-020 SHALL discard a reset asserted mid-press; after release of reset, a still-held key SHALL be debounced as a fresh press.

Configuration
REQ-021 SHALL support macro KEYPAD_AUTOCOMMIT_EN: when defined, a pending letter with no key event for TAP_TIMEOUT cycles SHALL commit as in REQ-016. When undefined, only the commit key commits and the timeout counter SHALL not exist.

Structure
REQ-022 SHALL place the key-code typedef, the key role enum (LETTER, COMMIT, CLEAR, SUBMIT, NONE), the group-to-ASCII table and the group sizes in the shared package keypad_pkg.
REQ-023 SHALL implement the scan and debounce logic (REQ-010 to REQ-012) as sub-module keypad_scanner, which outputs key_event, key_code and key_error.

Verification (SCAN_DWELL=2, DEBOUNCE_SCANS=2, TAP_TIMEOUT=200)
REQ-024 SHALL cover: PQRS key (R2C0) tapped twice, then commit -> preview 'Q', then char_out=8'h51 with one char_valid pulse and preview=8'h20.
REQ-025 SHALL cover: PQRS key tapped 5 times -> preview 'P' (wrap).
REQ-026 SHALL cover: ABC tap, then DEF tap, then commit -> single char_out 'D'; 'A' never emitted.
REQ-027 SHALL cover: R0 and R1 high together on C1 -> key_error pulse, preview unchanged.
REQ-028 SHALL cover: a key held 10 scans -> exactly one event; nRst pulsed mid-hold -> preview=8'h20, col=4'b0001, no char_valid.
REQ-029 SHALL cover, with KEYPAD_AUTOCOMMIT_EN: GHI tap, idle 200 cycles -> char_out 'G'; without the macro -> no output.
